game_flow_ctrl: RTL

Top-level game sequencer that drives the on-screen UI renderer and the gameplay datapath.
- Owns the screen/stage state (title, staff, three stages, success screens, fail screen) and the menu cursor.
- Tracks per-stage progress: keys found, current task, lives, and which stages are unlocked.
- Consumes debounced push-button levels and single-cycle gameplay event pulses; all outputs are registered and feed the renderer directly.

---
 rtl/game_pkg.sv | 39 +++
 rtl/btn_edge.sv | 24 ++
 rtl/game_flow_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Purpose: shared screen/task codes and menu limits for the game sequencer and the UI renderer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package game_pkg;

    typedef enum logic [3:0] {
        ST_TITLE    = 4'd0,
        ST_STAFF    = 4'd1,
        ST_STAGE1   = 4'd2,
        ST_SUCCESS1 = 4'd3,
        ST_STAGE2   = 4'd4,
        ST_SUCCESS2 = 4'd5,
        ST_STAGE3   = 4'd6,
        ST_SUCCESS3 = 4'd7,
        ST_FAIL     = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        TODO_NONE       = 2'd0,
        TODO_FIND_KEY   = 2'd1,
        TODO_FIND_LIGHT = 2'd2,
        TODO_FIND_DOOR  = 2'd3
    } todo_e;

    localparam logic [1:0] LIFE_MAX       = 2'd3;
    localparam int         NUM_STAGES     = 3;
    localparam logic [1:0] TITLE_SEL_MAX  = 2'd2;  // TITLE offers stage 1..3
    localparam logic [1:0] SUB_SEL_MAX    = 2'd1;  // SUCCESSn/FAIL offer next-or-retry / back
    localparam logic [3:0] PLAY_VALID_RST = 4'b0011;

    // Task handed to the player when a stage is (re)entered.
    function automatic logic [1:0] first_todo(input logic [3:0] stage);
        if (stage == ST_STAGE2) begin
            return TODO_FIND_LIGHT;
        end
        return TODO_FIND_KEY;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Purpose: rising-edge detector for one debounced push-button level.
// Latency: combinational pulse in the cycle the level first reads high after being low.
// Backpressure: none; the pulse is a one-cycle event.
// Ports: clk, rst_n (sync, active-low), btn_i (level), rise_o (edge pulse).
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    logic lvl_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_q <= 1'b0;
        end else begin
            lvl_q <= btn_i;
        end
    end

    assign rise_o = btn_i & ~lvl_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Purpose: game screen/stage sequencer: menu cursor, stage progress, lives and stage unlocks.
// Latency: every output is registered and updates on the edge after the causing button edge/event.
// Backpressure: none; button edges and event pulses are consumed in the cycle they arrive.
// Ports: clk, rst_n (sync, active-low); btn_up/btn_down/btn_enter levels; ev_key/ev_light/ev_door/ev_hit
//        pulses; state, menu_sel, key_find, todo, life, play_valid, stage_start to the renderer.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int INVULN_CYCLES = 25000000,
    parameter int KEYS_NEEDED   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_enter,
    input  logic       ev_key,
    input  logic       ev_light,
    input  logic       ev_door,
    input  logic       ev_hit,
    output logic [3:0] state,
    output logic [1:0] menu_sel,
    output logic [1:0] key_find,
    output logic [1:0] todo,
    output logic [1:0] life,
    output logic [3:0] play_valid,
    output logic       stage_start
);

    localparam int               INV_W    = $clog2(INVULN_CYCLES + 1);
    localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INVULN_CYCLES);
    localparam logic [INV_W-1:0] INV_ONE  = INV_W'(1);
    localparam logic [1:0]       KEYS_LD  = 2'(KEYS_NEEDED);

    logic up_rise, dn_rise, en_rise;

    btn_edge u_up (.clk(clk), .rst_n(rst_n), .btn_i(btn_up),    .rise_o(up_rise));
    btn_edge u_dn (.clk(clk), .rst_n(rst_n), .btn_i(btn_down),  .rise_o(dn_rise));
    btn_edge u_en (.clk(clk), .rst_n(rst_n), .btn_i(btn_enter), .rise_o(en_rise));

    logic [3:0]       state_q, state_d, last_q, last_d;
    logic [1:0]       sel_q, sel_d, key_q, key_d, todo_q, todo_d, life_q, life_d;
    logic [3:0]       pv_q, pv_d;
    logic             ss_q, ss_d;
    logic [INV_W-1:0] inv_q, inv_d;

    logic       enter_stage, goto_menu, key_cnt;
    logic [3:0] stage_tgt, menu_tgt;
    logic [1:0] key_next, sel_max;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        sel_d       = sel_q;
        key_d       = key_q;
        todo_d      = todo_q;
        life_d      = life_q;
        pv_d        = pv_q;
        ss_d        = 1'b0;
        inv_d       = (inv_q != '0) ? inv_q - INV_ONE : '0;
        enter_stage = 1'b0;
        goto_menu   = 1'b0;
        stage_tgt   = ST_STAGE1;
        menu_tgt    = ST_TITLE;
        sel_max     = (state_q == ST_TITLE) ? TITLE_SEL_MAX : SUB_SEL_MAX;
        // Keys count only against the task held before this cycle's update.
        key_cnt     = ev_key && (todo_q == TODO_FIND_KEY) && (key_q != 2'd3);
        key_next    = key_q + {1'b0, key_cnt};

        case (state_q)
            ST_TITLE, ST_SUCCESS1, ST_SUCCESS2, ST_FAIL: begin
                if (en_rise) begin
                    if (state_q == ST_TITLE) begin
                        if (sel_q == 2'd0) begin
                            enter_stage = 1'b1;
                            stage_tgt   = ST_STAGE1;
                        end else if (sel_q == 2'd1 && pv_q[2]) begin
                            enter_stage = 1'b1;
                            stage_tgt   = ST_STAGE2;
                        end else if (sel_q == 2'd2 && pv_q[3]) begin
                            enter_stage = 1'b1;
                            stage_tgt   = ST_STAGE3;
                        end
                    end else if (sel_q == 2'd0) begin
                        enter_stage = 1'b1;
                        if (state_q == ST_SUCCESS1) begin
                            stage_tgt = ST_STAGE2;
                        end else if (state_q == ST_SUCCESS2) begin
                            stage_tgt = ST_STAGE3;
                        end else begin
                            stage_tgt = last_q;
                        end
                    end else begin
                        goto_menu = 1'b1;
                        menu_tgt  = ST_TITLE;
                    end
                end else if (up_rise) begin
                    if (sel_q != 2'd0) sel_d = sel_q - 2'd1;
                end else if (dn_rise) begin
                    if (sel_q < sel_max) sel_d = sel_q + 2'd1;
                end
            end
            ST_SUCCESS3: begin
                if (en_rise) begin
                    goto_menu = 1'b1;
                    menu_tgt  = ST_STAFF;
                end
            end
            ST_STAFF: begin
                if (en_rise) begin
                    goto_menu = 1'b1;
                    menu_tgt  = ST_TITLE;
                end
            end
            ST_STAGE1, ST_STAGE2, ST_STAGE3: begin
                if (ev_door && todo_q == TODO_FIND_DOOR) begin
                    // A winning door beats a same-cycle hit; SUCCESSn is the next code.
                    goto_menu = 1'b1;
                    menu_tgt  = state_q + 4'd1;
                end else begin
                    if (key_cnt) begin
                        key_d = key_next;
                        if (key_next == KEYS_LD) todo_d = TODO_FIND_DOOR;
                    end
                    if (ev_light && todo_q == TODO_FIND_LIGHT) begin
                        todo_d = TODO_FIND_KEY;
                    end
                    if (state_q == ST_STAGE3 && ev_hit && inv_q == '0 && life_q != 2'd0) begin
                        life_d = life_q - 2'd1;
                        inv_d  = INV_LOAD;
                        if (life_q == 2'd1) begin
                            goto_menu = 1'b1;
                            menu_tgt  = ST_FAIL;
                        end
                    end
                end
            end
            default: begin
                goto_menu = 1'b1;
                menu_tgt  = ST_TITLE;
            end
        endcase

        if (enter_stage) begin
            state_d = stage_tgt;
            last_d  = stage_tgt;
            sel_d   = 2'd0;
            key_d   = 2'd0;
            life_d  = LIFE_MAX;
            inv_d   = '0;
            todo_d  = first_todo(stage_tgt);
            ss_d    = 1'b1;
        end else if (goto_menu) begin
            state_d = menu_tgt;
            sel_d   = 2'd0;
            todo_d  = TODO_NONE;
            if (menu_tgt == ST_SUCCESS1) pv_d[2] = 1'b1;
            if (menu_tgt == ST_SUCCESS2) pv_d[3] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_TITLE;
            last_q  <= ST_STAGE1;
            sel_q   <= 2'd0;
            key_q   <= 2'd0;
            todo_q  <= TODO_NONE;
            life_q  <= LIFE_MAX;
            pv_q    <= PLAY_VALID_RST;
            ss_q    <= 1'b0;
            inv_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            key_q   <= key_d;
            todo_q  <= todo_d;
            life_q  <= life_d;
            pv_q    <= pv_d;
            ss_q    <= ss_d;
            inv_q   <= inv_d;
        end
    end

    assign state       = state_q;
    assign menu_sel    = sel_q;
    assign key_find    = key_q;
    assign todo        = todo_q;
    assign life        = life_q;
    assign play_valid  = pv_q;
    assign stage_start = ss_q;

endmodule
